// File: rtl/axi_scratch_slave.sv
// axi_scratch_slave: AXI4 slave backed by a DEPTH x 64-bit scratchpad held in flops.
// Independent read and write FSMs, one outstanding transaction each, 8-byte beats only.
module axi_scratch_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 32
) (
    input  logic        aclk,
    input  logic        areset,
    // write address
    input  logic [31:0] s_axi_awaddr,
    input  logic [1:0]  s_axi_awburst,
    input  logic [0:0]  s_axi_awid,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic        s_axi_awlock,
    input  logic [3:0]  s_axi_awcache,
    input  logic [2:0]  s_axi_awprot,
    input  logic [3:0]  s_axi_awqos,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    // write data
    input  logic [63:0] s_axi_wdata,
    input  logic [7:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    // write response
    output logic [0:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    // read address
    input  logic [31:0] s_axi_araddr,
    input  logic [1:0]  s_axi_arburst,
    input  logic [0:0]  s_axi_arid,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic        s_axi_arlock,
    input  logic [3:0]  s_axi_arcache,
    input  logic [2:0]  s_axi_arprot,
    input  logic [3:0]  s_axi_arqos,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    // read data
    output logic [63:0] s_axi_rdata,
    output logic [0:0]  s_axi_rid,
    output logic        s_axi_rlast,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          IW          = $clog2(DEPTH);
    localparam logic [31:0] WIN_MASK    = ~(32'(DEPTH * 8) - 32'd1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Address-phase response: out-of-window outranks a bad beat size.
    function automatic logic [1:0] addr_resp(input logic [31:0] addr, input logic [2:0] size);
        if ((addr & WIN_MASK) != BASE_ADDR) return RESP_DECERR;
        if (size != 3'b011)                 return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic [63:0]   mem [DEPTH];

    w_state_t      w_state;
    logic [IW-1:0] w_idx;
    logic [7:0]    w_len;
    logic [7:0]    w_cnt;
    logic          w_fixed;
    logic [0:0]    w_id;
    logic [1:0]    w_resp;
    logic          w_last_err;

    r_state_t      r_state;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt;
    logic          r_fixed;
    logic          r_ok;

    logic [IW-1:0] aw_idx;
    logic [IW-1:0] ar_idx;
    logic [1:0]    ar_resp;
    logic          w_fire;
    logic          mem_we;

    assign aw_idx  = s_axi_awaddr[3 +: IW];
    assign ar_idx  = s_axi_araddr[3 +: IW];
    assign ar_resp = addr_resp(s_axi_araddr, s_axi_arsize);
    assign w_fire  = s_axi_wvalid && s_axi_wready;
    assign mem_we  = w_fire && (w_resp == RESP_OKAY);

    logic unused_sideband;
    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

    // NOTE: the scratchpad is built from flops precisely so reset can clear every word;
    // an inferred RAM has no reset and would silently break that guarantee.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            for (int k = 0; k < 8; k++)
                if (s_axi_wstrb[k]) mem[w_idx][8*k +: 8] <= s_axi_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_idx         <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_fixed       <= 1'b0;
            w_id          <= '0;
            w_resp        <= RESP_OKAY;
            w_last_err    <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_state       <= W_DATA;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_idx         <= aw_idx;
                        w_len         <= s_axi_awlen;
                        w_cnt         <= '0;
                        w_fixed       <= (s_axi_awburst == BURST_FIXED);
                        w_id          <= s_axi_awid;
                        w_resp        <= addr_resp(s_axi_awaddr, s_axi_awsize);
                        w_last_err    <= 1'b0;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (!w_fixed) w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            w_state      <= W_RESP;
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            if (w_resp != RESP_OKAY)             s_axi_bresp <= w_resp;
                            else if (w_last_err || !s_axi_wlast) s_axi_bresp <= RESP_SLVERR;
                            else                                 s_axi_bresp <= RESP_OKAY;
                        end else if (s_axi_wlast) begin
                            w_last_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state       <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // r_idx always points at the word for the beat after the one currently presented.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_idx         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_fixed       <= 1'b0;
            r_ok          <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_state       <= R_DATA;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rresp   <= ar_resp;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
                        r_idx         <= (s_axi_arburst == BURST_FIXED) ? ar_idx : ar_idx + 1'b1;
                        r_len         <= s_axi_arlen;
                        r_cnt         <= '0;
                        r_fixed       <= (s_axi_arburst == BURST_FIXED);
                        r_ok          <= (ar_resp == RESP_OKAY);
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            r_state       <= R_IDLE;
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                        end else begin
                            r_cnt       <= r_cnt + 8'd1;
                            s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                            s_axi_rdata <= r_ok ? mem[r_idx] : '0;
                            if (!r_fixed) r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_scratch_slave.sv
// Self-checking bench for axi_scratch_slave: a reference memory model feeds queues of
// expected B responses and R beats, which are popped as the DUT produces them.
module tb_axi_scratch_slave;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] awaddr = '0;
    logic [1:0]  awburst = '0;
    logic [0:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'b011;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [0:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [1:0]  arburst = '0;
    logic [0:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b011;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [0:0]  rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 aclk = ~aclk;

    axi_scratch_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awburst(awburst), .s_axi_awid(awid), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awlock(1'b0), .s_axi_awcache(4'h3), .s_axi_awprot(3'b010),
        .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arburst(arburst), .s_axi_arid(arid), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arlock(1'b0), .s_axi_arcache(4'h3), .s_axi_arprot(3'b010),
        .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rlast(rlast), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [0:0]  id;
    } r_exp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [0:0] id;
    } b_exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model [DEPTH];
    logic [63:0] wtab  [256];
    r_exp_t      r_q [$];
    b_exp_t      b_q [$];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size);
        if ((addr & ~32'(DEPTH * 8 - 1)) != BASE) return 2'b11;
        if (size != 3'b011) return 2'b10;
        return 2'b00;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Full write burst; beat data comes from wtab. bad_last drops wlast on the final beat.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] strb, input logic [0:0] id,
                            input bit bad_last);
        logic [1:0] ar;
        b_exp_t     be;
        int         idx;
        int         n;
        ar  = exp_resp(addr, size);
        idx = int'(addr[7:3]);
        for (int i = 0; i <= int'(len); i++) begin
            if (ar == 2'b00)
                for (int k = 0; k < 8; k++)
                    if (strb[k]) model[idx][8*k +: 8] = wtab[i][8*k +: 8];
            if (burst != FIXED) idx = (idx + 1) % DEPTH;
        end
        be.resp = (ar != 2'b00) ? ar : (bad_last ? 2'b10 : 2'b00);
        be.id   = id;
        b_q.push_back(be);

        awaddr = addr; awlen = len; awburst = burst; awsize = size; awid = id; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin tick(); n++; end
        n_checks++;
        if (awready !== 1'b1) begin
            n_errors++;
            $display("FAIL aw_handshake: awready=%b required 1", awready);
        end
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wtab[i]; wstrb = strb; wlast = (i == int'(len)) && !bad_last; wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin tick(); n++; end
            if (wready !== 1'b1) begin
                n_checks++; n_errors++;
                $display("FAIL w_handshake: beat %0d wready=%b required 1", i, wready);
            end
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL b_latency: bvalid=%b required 1 one cycle after last W", bvalid);
        end
        n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        be = b_q.pop_front();
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== be.resp || bid !== be.id) begin
            n_errors++;
            $display("FAIL b_resp: bvalid=%b bresp=%b bid=%b required 1 %b %b", bvalid, bresp, bid, be.resp, be.id);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    // Full read burst; when stall_at >= 0 rready is held low for 3 cycles on that beat.
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [0:0] id, input int stall_at);
        logic [1:0] ar;
        r_exp_t     e;
        r_exp_t     held;
        int         idx;
        int         n;
        ar  = exp_resp(addr, size);
        idx = int'(addr[7:3]);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = (ar == 2'b00) ? model[idx] : 64'h0;
            e.last = (i == int'(len));
            e.resp = ar;
            e.id   = id;
            r_q.push_back(e);
            if (burst != FIXED) idx = (idx + 1) % DEPTH;
        end

        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin tick(); n++; end
        n_checks++;
        if (arready !== 1'b1) begin
            n_errors++;
            $display("FAIL ar_handshake: arready=%b required 1", arready);
        end
        tick();
        arvalid = 1'b0;
        rready  = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            // first beat: one cycle after AR; later beats: one cycle after each R handshake
            n_checks++;
            if (rvalid !== 1'b1) begin
                n_errors++;
                $display("FAIL r_timing: beat %0d rvalid=%b required 1", i, rvalid);
            end
            n = 0;
            while (!rvalid && n < 50) begin tick(); n++; end
            if (i == stall_at) begin
                rready = 1'b0;
                held   = '{data: rdata, last: rlast, resp: rresp, id: rid};
                repeat (3) begin
                    tick();
                    n_checks++;
                    if (rvalid !== 1'b1 || {rdata, rlast, rresp, rid} !== held) begin
                        n_errors++;
                        $display("FAIL r_stall_stable: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                                 rvalid, rdata, rlast, held.data, held.last);
                    end
                end
                rready = 1'b1;
            end
            e = r_q.pop_front();
            n_checks++;
            if (rdata !== e.data || rlast !== e.last || rresp !== e.resp || rid !== e.id) begin
                n_errors++;
                $display("FAIL r_beat %0d: rdata=%h rlast=%b rresp=%b rid=%b required %h %b %b %b",
                         i, rdata, rlast, rresp, rid, e.data, e.last, e.resp, e.id);
            end
            tick();
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0 ||
            {bresp, rresp, bid, rid} !== 6'b0 || rdata !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b rlast=%b bresp=%b rresp=%b rdata=%h required all 0",
                     awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata);
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: awready=%b arready=%b required 1 1", awready, arready);
        end
        clear_model();
    endtask

    task automatic test_incr_burst();
        wtab[0] = 64'h11; wtab[1] = 64'h22; wtab[2] = 64'h33; wtab[3] = 64'h44;
        do_write(BASE, 8'd3, INCR, 3'b011, 8'hFF, 1'b1, 1'b0);
        do_read(BASE, 8'd3, INCR, 3'b011, 1'b1, -1);
    endtask

    task automatic test_strobe();
        wtab[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(BASE + 32'd40, 8'd0, INCR, 3'b011, 8'hFF, 1'b0, 1'b0);
        wtab[0] = 64'hAAAA_AAAA_BBBB_BBBB;
        do_write(BASE + 32'd40, 8'd0, INCR, 3'b011, 8'h0F, 1'b0, 1'b0);
        do_read(BASE + 32'd40, 8'd0, INCR, 3'b011, 1'b0, -1);
    endtask

    task automatic test_wrap_index();
        for (int i = 0; i < 4; i++) wtab[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        do_write(BASE + 32'(30 * 8), 8'd3, INCR, 3'b011, 8'hFF, 1'b1, 1'b0);
        do_read(BASE + 32'(30 * 8), 8'd0, INCR, 3'b011, 1'b0, -1);
        do_read(BASE + 32'(31 * 8), 8'd0, INCR, 3'b011, 1'b0, -1);
        do_read(BASE + 32'(0 * 8),  8'd0, INCR, 3'b011, 1'b0, -1);
        do_read(BASE + 32'(1 * 8),  8'd0, INCR, 3'b011, 1'b0, -1);
        do_read(BASE + 32'(30 * 8), 8'd3, WRAP, 3'b011, 1'b1, -1);
    endtask

    task automatic test_fixed_burst();
        wtab[0] = 64'h0F0F_0001; wtab[1] = 64'h0F0F_0002; wtab[2] = 64'h0F0F_0003;
        do_write(BASE + 32'd96, 8'd2, FIXED, 3'b011, 8'hFF, 1'b0, 1'b0);
        do_read(BASE + 32'd104, 8'd0, INCR, 3'b011, 1'b0, -1);
        do_read(BASE + 32'd96, 8'd2, FIXED, 3'b011, 1'b1, -1);
    endtask

    task automatic test_errors();
        do_read(BASE + 32'h1000, 8'd1, INCR, 3'b011, 1'b0, -1);
        wtab[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        do_write(BASE + 32'h1000, 8'd0, INCR, 3'b011, 8'hFF, 1'b1, 1'b0);
        do_read(BASE, 8'd0, INCR, 3'b011, 1'b0, -1);
        do_write(BASE + 32'd16, 8'd0, INCR, 3'b010, 8'hFF, 1'b0, 1'b0);
        do_read(BASE + 32'd16, 8'd0, INCR, 3'b010, 1'b0, -1);
        do_read(BASE + 32'd16, 8'd0, INCR, 3'b011, 1'b0, -1);
        wtab[0] = 64'h5151_0000; wtab[1] = 64'h5151_0001;
        do_write(BASE + 32'd24, 8'd1, INCR, 3'b011, 8'hFF, 1'b1, 1'b1);
        do_read(BASE + 32'd24, 8'd1, INCR, 3'b011, 1'b1, -1);
    endtask

    task automatic test_backpressure();
        do_read(BASE, 8'd3, INCR, 3'b011, 1'b0, 1);
    endtask

    task automatic test_collision();
        logic [63:0] old_val;
        wtab[0] = 64'h1234_5678_9ABC_DEF0;
        do_write(BASE + 32'd72, 8'd0, INCR, 3'b011, 8'hFF, 1'b0, 1'b0);
        old_val = model[9];
        awaddr = BASE + 32'd72; awlen = 8'd0; awburst = INCR; awsize = 3'b011; awvalid = 1'b1;
        while (!awready) tick();
        tick();
        awvalid = 1'b0;
        wdata = 64'h0BAD_F00D_0BAD_F00D; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
        araddr = BASE + 32'd72; arlen = 8'd0; arburst = INCR; arsize = 3'b011; arid = 1'b0; arvalid = 1'b1;
        n_checks++;
        if (wready !== 1'b1 || arready !== 1'b1) begin
            n_errors++;
            $display("FAIL collision_setup: wready=%b arready=%b required 1 1", wready, arready);
        end
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== old_val) begin
            n_errors++;
            $display("FAIL collision_read: rvalid=%b rdata=%h required 1 %h", rvalid, rdata, old_val);
        end
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_errors++;
            $display("FAIL collision_bresp: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        model[9] = 64'h0BAD_F00D_0BAD_F00D;
        do_read(BASE + 32'd72, 8'd0, INCR, 3'b011, 1'b0, -1);
    endtask

    task automatic test_reset_mid_burst();
        int bad;
        awaddr = BASE; awlen = 8'd7; awburst = INCR; awsize = 3'b011; awvalid = 1'b1;
        while (!awready) tick();
        tick();
        awvalid = 1'b0;
        wdata = 64'h5555_5555; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        tick();
        wdata = 64'h6666_6666;
        #2 areset = 1'b1;
        #1;
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: aw=%b w=%b b=%b ar=%b r=%b required 0",
                     awready, wready, bvalid, arready, rvalid);
        end
        @(posedge aclk);
        tick();
        areset = 1'b0; wvalid = 1'b0;
        tick();
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_release: awready=%b wready=%b required 1 0", awready, wready);
        end
        bad = 0;
        repeat (4) begin
            if (bvalid !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL mid_reset_no_b: bvalid seen high %0d cycles required 0", bad);
        end
        clear_model();
        do_read(BASE, 8'(DEPTH - 1), INCR, 3'b011, 1'b0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_incr_burst();
        test_strobe();
        test_wrap_index();
        test_fixed_burst();
        test_errors();
        test_backpressure();
        test_collision();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
